eeprom_i2c_master: RTL and testbench



---
 rtl/eeprom_i2c_master.sv | 232 +++++++++++++++++++++++
 tb/tb_eeprom_i2c_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_i2c_master.sv
// eeprom_i2c_master: single-byte random write / random read I2C initiator
// for AT24C02..16-style EEPROMs (11-bit address = ctrl block bits + byte).
module eeprom_i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART,
        RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    bit_q, bit_d;
    logic          rw_q, rw_d;
    logic [10:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          nack_q, nack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic [7:0]    tx_byte;
    logic          qend, slot_end, samp;

    assign qend     = cnt_q == CW'(CLK_DIV - 1);
    assign slot_end = qend && (qtr_q == 2'd3);
    assign samp     = (qtr_q == 2'd3) && (cnt_q == '0);

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = err_q;
    assign scl     = scl_q;
    assign sda     = sda_q ? 1'bz : 1'b0;

    // idx 0: ctrl W, 1: address byte, 2: ctrl R (read) or data (write)
    always_comb begin
        unique case (idx_q)
            2'd0:    tx_byte = {4'b1010, addr_q[10:8], 1'b0};
            2'd1:    tx_byte = addr_q[7:0];
            default: tx_byte = rw_q ? {4'b1010, addr_q[10:8], 1'b1}
                                    : wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    idx_d   = 2'd0;
                    bit_d   = 3'd0;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    rx_d    = 8'h00;
                    nack_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (qend) begin
                    cnt_d = '0;
                    qtr_d = qtr_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (samp && state_q == RX_ACK)
                    nack_d = sda;
                if (samp && state_q == RX_BYTE)
                    rx_d = {rx_q[6:0], sda};
                if (slot_end) begin
                    unique case (state_q)
                        START: begin
                            state_d = TX_BYTE;
                            bit_d   = 3'd0;
                        end
                        TX_BYTE: begin
                            if (bit_q == 3'd7)
                                state_d = RX_ACK;
                            else
                                bit_d = bit_q + 3'd1;
                        end
                        RX_ACK: begin
                            bit_d = 3'd0;
                            if (nack_q) begin
                                state_d = STOP;
                            end else if (idx_q == 2'd0) begin
                                state_d = TX_BYTE;
                                idx_d   = 2'd1;
                            end else if (idx_q == 2'd1) begin
                                state_d = rw_q ? RSTART : TX_BYTE;
                                idx_d   = 2'd2;
                            end else begin
                                state_d = rw_q ? RX_BYTE : STOP;
                            end
                        end
                        RSTART: begin
                            state_d = TX_BYTE;
                            bit_d   = 3'd0;
                        end
                        RX_BYTE: begin
                            if (bit_q == 3'd7)
                                state_d = TX_NACK;
                            else
                                bit_d = bit_q + 3'd1;
                        end
                        TX_NACK: state_d = STOP;
                        STOP: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            err_d   = nack_q;
                            if (rw_q && !nack_q)
                                rdata_d = rx_q;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Pin levels follow the next slot position so they stay registered;
    // Q0 holds sda so it never moves while scl is falling.
    always_comb begin
        busy_d = (state_d != IDLE) && (state_d != DONE);
        scl_d  = 1'b1;
        sda_d  = sda_q;
        unique case (state_d)
            IDLE, DONE: sda_d = 1'b1;
            START: sda_d = qtr_d < 2'd2;
            TX_BYTE: begin
                scl_d = qtr_d[1];
                if (qtr_d != 2'd0)
                    sda_d = tx_byte[3'd7 - bit_d];
            end
            RX_ACK, RX_BYTE, TX_NACK: begin
                scl_d = qtr_d[1];
                if (qtr_d != 2'd0)
                    sda_d = 1'b1;
            end
            RSTART: begin
                scl_d = qtr_d[1];
                if (qtr_d == 2'd3 && cnt_d >= CW'(CLK_DIV / 2))
                    sda_d = 1'b0;
                else if (qtr_d != 2'd0)
                    sda_d = 1'b1;
            end
            STOP: begin
                scl_d = qtr_d[1];
                if (qtr_d == 2'd3)
                    sda_d = 1'b1;
                else if (qtr_d != 2'd0)
                    sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qtr_q   <= 2'd0;
            idx_q   <= 2'd0;
            bit_q   <= 3'd0;
            rw_q    <= 1'b0;
            addr_q  <= 11'h000;
            wdata_q <= 8'h00;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end
endmodule

// File: tb/tb_eeprom_i2c_master.sv
// tb_eeprom_i2c_master: directed bench with a small EEPROM responder
// on the open-drain bus; expected values are hand-computed constants.
module tb_eeprom_i2c_master;
    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;
    localparam int WR_LAT  = 1 + 116 * CLK_DIV;
    localparam int RD_LAT  = 1 + 156 * CLK_DIV;
    localparam int NS_LAT  = 1 + 44 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [10:0] addr = 11'h000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        busy, done, ack_err, scl;
    wire         sda;

    pullup (sda);

    int compared = 0;
    int mismatched = 0;
    int lat, nd, base_log, base_st;

    always #5 clk = ~clk;

    eeprom_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    // Responder: all bus decoding lives in one process
    bit   [7:0]  mem [0:2047];
    logic        slv_en = 1'b1;
    logic        drv = 1'b0;
    logic        scl_p = 1'b1, sda_p = 1'b1;
    logic        rdm = 1'b0, mack = 1'b0;
    logic [10:0] ptr = 11'h000;
    logic [7:0]  sh = 8'h00;
    int          mode = 0, bitn = 0, bytn = 0, starts = 0;
    logic [7:0]  log_q [$];

    assign sda = drv ? 1'b0 : 1'bz;

    always @(scl or sda) begin
        if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b1 && sda === 1'b0) begin
            mode = 1; bitn = 0; bytn = 0; rdm = 1'b0; drv = 1'b0;
            mack = 1'b0; starts++;
        end else if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b0 && sda === 1'b1) begin
            mode = 0; drv = 1'b0;
        end else if (scl === 1'b1 && scl_p === 1'b0) begin
            if (mode == 1) begin
                sh = {sh[6:0], sda}; bitn++;
            end else if (mode == 3) begin
                bitn++;
            end else if (mode == 4) begin
                mack = sda;
            end
        end else if (scl === 1'b0 && scl_p === 1'b1) begin
            if (mode == 1 && bitn == 8) begin
                log_q.push_back(sh);
                if (slv_en) begin
                    if (bytn == 0) begin
                        rdm = sh[0]; ptr[10:8] = sh[3:1];
                    end else if (bytn == 1) begin
                        ptr[7:0] = sh;
                    end else begin
                        mem[ptr] = sh;
                    end
                    bytn++; drv = 1'b1; mode = 2;
                end else begin
                    mode = 0;
                end
            end else if (mode == 2) begin
                drv = 1'b0; bitn = 0;
                if (rdm) begin
                    sh = mem[ptr]; mode = 3; drv = ~sh[7];
                end else begin
                    mode = 1;
                end
            end else if (mode == 3) begin
                if (bitn == 8) begin
                    drv = 1'b0; mode = 4;
                end else begin
                    drv = ~sh[7 - bitn];
                end
            end else if (mode == 4) begin
                mode = 0;
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    function automatic logic [7:0] lg(input int i);
        int k = base_log + i;
        return (k < log_q.size()) ? log_q[k] : 8'hxx;
    endfunction

    // Runs one transaction; optionally pulses start again at cycle inj
    // with inverted addr/wdata. lat = -1 if done never comes.
    task automatic xfer(input logic r, input logic [10:0] a,
                        input logic [7:0] d, input int inj,
                        output int l, output int n_done);
        l = -1;
        n_done = 0;
        base_log = log_q.size();
        base_st = starts;
        @(negedge clk);
        rw = r; addr = a; wdata = d; start = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            start = (n == inj);
            if (n == inj) begin
                addr = ~a; wdata = ~d;
            end
            if (done === 1'b1) begin
                n_done++;
                if (l < 0) l = n;
            end
            if (l >= 0 && n >= l + 20) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (scl !== 1'b1) begin mismatched++; $display("FAIL rst_scl: got %b want 1", scl); end
        compared++; if (sda !== 1'b1) begin mismatched++; $display("FAIL rst_sda: got %b want 1", sda); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", done); end
        compared++; if (ack_err !== 1'b0) begin mismatched++; $display("FAIL rst_ack_err: got %b want 0", ack_err); end
        compared++; if (rdata !== 8'h00) begin mismatched++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        xfer(1'b0, 11'h123, 8'h5A, 0, lat, nd);
        compared++; if (lat !== WR_LAT) begin mismatched++; $display("FAIL wr_latency: got %0d want %0d", lat, WR_LAT); end
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL wr_done_count: got %0d want 1", nd); end
        compared++; if (ack_err !== 1'b0) begin mismatched++; $display("FAIL wr_ack_err: got %b want 0", ack_err); end
        compared++; if (lg(0) !== 8'hA2) begin mismatched++; $display("FAIL wr_ctrl: got %h want a2", lg(0)); end
        compared++; if (lg(1) !== 8'h23) begin mismatched++; $display("FAIL wr_addr: got %h want 23", lg(1)); end
        compared++; if (lg(2) !== 8'h5A) begin mismatched++; $display("FAIL wr_data: got %h want 5a", lg(2)); end
        compared++; if (mem[11'h123] !== 8'h5A) begin mismatched++; $display("FAIL wr_mem: got %h want 5a", mem[11'h123]); end
        compared++; if (scl !== 1'b1 || sda !== 1'b1) begin mismatched++; $display("FAIL wr_idle_bus: got %b%b want 11", scl, sda); end
    endtask

    task automatic test_boundary();
        xfer(1'b0, 11'h000, 8'hFF, 0, lat, nd);
        compared++; if (lg(0) !== 8'hA0) begin mismatched++; $display("FAIL bnd_ctrl_w0: got %h want a0", lg(0)); end
        compared++; if (mem[11'h000] !== 8'hFF) begin mismatched++; $display("FAIL bnd_mem0: got %h want ff", mem[11'h000]); end
        xfer(1'b0, 11'h7FF, 8'h00, 0, lat, nd);
        compared++; if (lg(0) !== 8'hAE) begin mismatched++; $display("FAIL bnd_ctrl_w7ff: got %h want ae", lg(0)); end
        compared++; if (lg(1) !== 8'hFF) begin mismatched++; $display("FAIL bnd_addr_7ff: got %h want ff", lg(1)); end
        xfer(1'b1, 11'h000, 8'h00, 0, lat, nd);
        compared++; if (lg(2) !== 8'hA1) begin mismatched++; $display("FAIL bnd_ctrl_r0: got %h want a1", lg(2)); end
        compared++; if (rdata !== 8'hFF) begin mismatched++; $display("FAIL bnd_rdata0: got %h want ff", rdata); end
        xfer(1'b1, 11'h7FF, 8'h00, 0, lat, nd);
        compared++; if (lg(2) !== 8'hAF) begin mismatched++; $display("FAIL bnd_ctrl_r7ff: got %h want af", lg(2)); end
        compared++; if (rdata !== 8'h00) begin mismatched++; $display("FAIL bnd_rdata7ff: got %h want 00", rdata); end
        compared++; if (lat !== RD_LAT) begin mismatched++; $display("FAIL bnd_rd_latency: got %0d want %0d", lat, RD_LAT); end
    endtask

    task automatic test_read();
        xfer(1'b1, 11'h123, 8'h00, 0, lat, nd);
        compared++; if (lat !== RD_LAT) begin mismatched++; $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT); end
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL rd_done_count: got %0d want 1", nd); end
        compared++; if (rdata !== 8'h5A) begin mismatched++; $display("FAIL rd_rdata: got %h want 5a", rdata); end
        compared++; if (ack_err !== 1'b0) begin mismatched++; $display("FAIL rd_ack_err: got %b want 0", ack_err); end
        compared++; if (lg(0) !== 8'hA2) begin mismatched++; $display("FAIL rd_ctrl_w: got %h want a2", lg(0)); end
        compared++; if (lg(1) !== 8'h23) begin mismatched++; $display("FAIL rd_addr: got %h want 23", lg(1)); end
        compared++; if (lg(2) !== 8'hA3) begin mismatched++; $display("FAIL rd_ctrl_r: got %h want a3", lg(2)); end
        compared++; if (starts - base_st !== 2) begin mismatched++; $display("FAIL rd_start_count: got %0d want 2", starts - base_st); end
        compared++; if (mack !== 1'b1) begin mismatched++; $display("FAIL rd_nack: got %b want 1", mack); end
        compared++; if (scl !== 1'b1 || sda !== 1'b1) begin mismatched++; $display("FAIL rd_idle_bus: got %b%b want 11", scl, sda); end
    endtask

    task automatic test_no_slave();
        slv_en = 1'b0;
        xfer(1'b1, 11'h123, 8'h00, 0, lat, nd);
        slv_en = 1'b1;
        compared++; if (lat !== NS_LAT) begin mismatched++; $display("FAIL ns_latency: got %0d want %0d", lat, NS_LAT); end
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL ns_done_count: got %0d want 1", nd); end
        compared++; if (ack_err !== 1'b1) begin mismatched++; $display("FAIL ns_ack_err: got %b want 1", ack_err); end
        compared++; if (rdata !== 8'h5A) begin mismatched++; $display("FAIL ns_rdata_kept: got %h want 5a", rdata); end
        compared++; if (log_q.size() - base_log !== 1) begin mismatched++; $display("FAIL ns_bytes_sent: got %0d want 1", log_q.size() - base_log); end
        compared++; if (scl !== 1'b1 || sda !== 1'b1) begin mismatched++; $display("FAIL ns_idle_bus: got %b%b want 11", scl, sda); end
    endtask

    task automatic test_busy_ignore();
        xfer(1'b0, 11'h755, 8'h11, 0, lat, nd);
        compared++; if (ack_err !== 1'b0) begin mismatched++; $display("FAIL bi_err_cleared: got %b want 0", ack_err); end
        xfer(1'b0, 11'h0AA, 8'h3C, 100, lat, nd);
        compared++; if (lat !== WR_LAT) begin mismatched++; $display("FAIL bi_latency: got %0d want %0d", lat, WR_LAT); end
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL bi_done_count: got %0d want 1", nd); end
        compared++; if (lg(1) !== 8'hAA) begin mismatched++; $display("FAIL bi_addr: got %h want aa", lg(1)); end
        compared++; if (lg(2) !== 8'h3C) begin mismatched++; $display("FAIL bi_data: got %h want 3c", lg(2)); end
        compared++; if (mem[11'h0AA] !== 8'h3C) begin mismatched++; $display("FAIL bi_mem: got %h want 3c", mem[11'h0AA]); end
        compared++; if (mem[11'h755] !== 8'h11) begin mismatched++; $display("FAIL bi_other_mem: got %h want 11", mem[11'h755]); end
    endtask

    task automatic test_back_to_back();
        xfer(1'b0, 11'h0F0, 8'h77, WR_LAT, lat, nd);
        compared++; if (nd !== 1) begin mismatched++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy: got %b want 0", busy); end
        compared++; if (mem[11'h0F0] !== 8'h77) begin mismatched++; $display("FAIL b2b_mem: got %h want 77", mem[11'h0F0]); end
        compared++; if (starts - base_st !== 1) begin mismatched++; $display("FAIL b2b_start_count: got %0d want 1", starts - base_st); end
    endtask

    task automatic test_reset_mid();
        int rp = 1 + 11 * SLOT + 5;
        @(negedge clk);
        rw = 1'b0; addr = 11'h321; wdata = 8'h99; start = 1'b1;
        for (int n = 1; n < rp; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rm_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compared++; if (scl !== 1'b1) begin mismatched++; $display("FAIL rm_scl: got %b want 1", scl); end
        compared++; if (sda !== 1'b1) begin mismatched++; $display("FAIL rm_sda: got %b want 1", sda); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rm_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rm_done: got %b want 0", done); end
        repeat (SLOT) @(negedge clk);
        compared++; if (busy !== 1'b0 || scl !== 1'b1) begin mismatched++; $display("FAIL rm_stays_idle: got %b%b want 01", busy, scl); end
        compared++; if (mem[11'h321] !== 8'h00) begin mismatched++; $display("FAIL rm_no_write: got %h want 00", mem[11'h321]); end
        xfer(1'b0, 11'h321, 8'h99, 0, lat, nd);
        compared++; if (lat !== WR_LAT) begin mismatched++; $display("FAIL rm_wr_latency: got %0d want %0d", lat, WR_LAT); end
        compared++; if (ack_err !== 1'b0) begin mismatched++; $display("FAIL rm_wr_ack_err: got %b want 0", ack_err); end
        compared++; if (mem[11'h321] !== 8'h99) begin mismatched++; $display("FAIL rm_wr_mem: got %h want 99", mem[11'h321]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_boundary();
        test_read();
        test_no_slave();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
